// File: rtl/serial_cmp_accumulator.sv
// serial_cmp_accumulator: bit-serial MSB-first word comparator fed by a 1-bit lt/gt/eq stream,
// with registered word result and saturating per-result tallies.
module serial_cmp_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             lt_in,
    input  logic             gt_in,
    input  logic             eq_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             err,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    localparam logic [1:0] D_UNDEC = 2'd0, D_LT = 2'd1, D_GT = 2'd2;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [1:0]    r_state;
    logic [BW-1:0] r_cnt;
    logic [1:0]    r_dec;
    logic          r_err_seen;
    logic          w_legal, w_err_n, w_last;
    logic [1:0]    w_dec_n;
    logic          w_inc_lt, w_inc_gt, w_inc_eq;
    assign w_legal  = $onehot({lt_in, gt_in, eq_in});
    // First legal non-equal bit fixes the decision; {gt,lt} encodes D_LT/D_GT directly.
    assign w_dec_n  = (r_dec == D_UNDEC && w_legal) ? {gt_in, lt_in} : r_dec;
    assign w_err_n  = r_err_seen | ~w_legal;
    assign w_last   = r_state == S_RUN && bit_valid && r_cnt == LAST;
    assign w_inc_lt = w_last && !w_err_n && w_dec_n == D_LT && lt_cnt != MAX;
    assign w_inc_gt = w_last && !w_err_n && w_dec_n == D_GT && gt_cnt != MAX;
    assign w_inc_eq = w_last && !w_err_n && w_dec_n == D_UNDEC && eq_cnt != MAX;
    assign busy     = r_state == S_RUN;
    assign done     = r_state == S_DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dec      <= D_UNDEC;
            r_err_seen <= 1'b0;
            lt         <= 1'b0;
            gt         <= 1'b0;
            eq         <= 1'b0;
            err        <= 1'b0;
            lt_cnt     <= '0;
            gt_cnt     <= '0;
            eq_cnt     <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_state    <= S_RUN;
                r_cnt      <= '0;
                r_dec      <= D_UNDEC;
                r_err_seen <= 1'b0;
            end
            if (r_state == S_RUN && bit_valid) begin
                r_dec      <= w_dec_n;
                r_err_seen <= w_err_n;
                r_state    <= (r_cnt == LAST) ? S_DONE : S_RUN;
                r_cnt      <= (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
            end
            if (r_state == S_DONE) r_state <= S_IDLE;
            // Results load on the final bit so they are valid alongside done.
            if (w_last) begin
                lt  <= !w_err_n && w_dec_n == D_LT;
                gt  <= !w_err_n && w_dec_n == D_GT;
                eq  <= !w_err_n && w_dec_n == D_UNDEC;
                err <= w_err_n;
            end
            lt_cnt <= lt_cnt + CNT_W'(w_inc_lt);
            gt_cnt <= gt_cnt + CNT_W'(w_inc_gt);
            eq_cnt <= eq_cnt + CNT_W'(w_inc_eq);
        end
    end
endmodule

// File: tb/tb_serial_cmp_accumulator.sv
// tb_serial_cmp_accumulator: scoreboard bench driving two instances (CNT_W=8 and CNT_W=2)
// from one bit stream; word codes are 0=eq 1=lt 2=gt 3=lt+gt 4=none 5=all.
module tb_serial_cmp_accumulator;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0;
    logic lt_in = 1'b0, gt_in = 1'b0, eq_in = 1'b0;
    logic busy, done, lt, gt, eq, err;
    logic [7:0] lt_cnt, gt_cnt, eq_cnt;
    logic busy2, done2, lt2, gt2, eq2, err2;
    logic [1:0] lt_cnt2, gt_cnt2, eq_cnt2;

    typedef logic [2:0] word_t [8];
    typedef struct packed {
        logic lt, gt, eq, err;
        logic [7:0] lc, gc, ec;
        logic [1:0] lc2, gc2, ec2;
    } exp_t;

    exp_t q[$];
    int n_checks = 0, n_pass = 0, n_done = 0;
    int m_lc = 0, m_gc = 0, m_ec = 0, m_lc2 = 0, m_gc2 = 0, m_ec2 = 0;

    serial_cmp_accumulator #(.WIDTH(8), .CNT_W(8)) d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in), .busy(busy), .done(done),
        .lt(lt), .gt(gt), .eq(eq), .err(err),
        .lt_cnt(lt_cnt), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt));

    serial_cmp_accumulator #(.WIDTH(8), .CNT_W(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in), .busy(busy2), .done(done2),
        .lt(lt2), .gt(gt2), .eq(eq2), .err(err2),
        .lt_cnt(lt_cnt2), .gt_cnt(gt_cnt2), .eq_cnt(eq_cnt2));

    always #5 clk = ~clk;
    always @(posedge clk) if (done) n_done <= n_done + 1;

    task automatic model_push(input word_t w);
        exp_t x;
        int dec = 0;
        bit bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (w[i] > 3'd2) bad = 1;
            else if (dec == 0) dec = int'(w[i]);
        end
        x.lt = !bad && dec == 1;
        x.gt = !bad && dec == 2;
        x.eq = !bad && dec == 0;
        x.err = bad;
        if (x.lt) begin m_lc = (m_lc < 255) ? m_lc + 1 : 255; m_lc2 = (m_lc2 < 3) ? m_lc2 + 1 : 3; end
        if (x.gt) begin m_gc = (m_gc < 255) ? m_gc + 1 : 255; m_gc2 = (m_gc2 < 3) ? m_gc2 + 1 : 3; end
        if (x.eq) begin m_ec = (m_ec < 255) ? m_ec + 1 : 255; m_ec2 = (m_ec2 < 3) ? m_ec2 + 1 : 3; end
        x.lc = 8'(m_lc); x.gc = 8'(m_gc); x.ec = 8'(m_ec);
        x.lc2 = 2'(m_lc2); x.gc2 = 2'(m_gc2); x.ec2 = 2'(m_ec2);
        q.push_back(x);
    endtask

    task automatic set_bit(input logic [2:0] c);
        bit_valid = 1'b1;
        lt_in = c == 3'd1 || c == 3'd3 || c == 3'd5;
        gt_in = c == 3'd2 || c == 3'd3 || c == 3'd5;
        eq_in = c == 3'd0 || c == 3'd5;
    endtask

    task automatic do_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_bit(input logic [2:0] c, input int gap);
        bit_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_in_gap: got %b want 1", busy); else n_pass++;
        end
        set_bit(c);
        @(negedge clk) bit_valid = 1'b0;
    endtask

    task automatic finish_word(input string tag);
        exp_t e;
        int k = 0;
        while (done !== 1'b1 && k < 4) begin @(negedge clk); k++; end
        n_checks++;
        if (done !== 1'b1 || k != 0) $display("FAIL %s_latency: done=%b late_cycles=%0d want done=1 late=0", tag, done, k);
        else n_pass++;
        e = q.pop_front();
        n_checks++;
        if ({lt, gt, eq, err} !== {e.lt, e.gt, e.eq, e.err})
            $display("FAIL %s_result: lt/gt/eq/err got %b want %b", tag, {lt, gt, eq, err}, {e.lt, e.gt, e.eq, e.err});
        else n_pass++;
        n_checks++;
        if ({lt_cnt, gt_cnt, eq_cnt} !== {e.lc, e.gc, e.ec})
            $display("FAIL %s_cnt8: got %0d/%0d/%0d want %0d/%0d/%0d", tag, lt_cnt, gt_cnt, eq_cnt, e.lc, e.gc, e.ec);
        else n_pass++;
        n_checks++;
        if ({lt_cnt2, gt_cnt2, eq_cnt2, busy} !== {e.lc2, e.gc2, e.ec2, 1'b0})
            $display("FAIL %s_cnt2_busy: got %0d/%0d/%0d busy=%b want %0d/%0d/%0d busy=0",
                     tag, lt_cnt2, gt_cnt2, eq_cnt2, busy, e.lc2, e.gc2, e.ec2);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic run_word(input word_t w, input int gap_max, input string tag);
        model_push(w);
        do_start();
        for (int i = 0; i < 8; i++) send_bit(w[i], gap_max == 0 ? 0 : int'($urandom_range(0, gap_max)));
        finish_word(tag);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, lt, gt, eq, err, lt_cnt, gt_cnt, eq_cnt} !== 30'd0)
            $display("FAIL reset_state: got %h want 0", {busy, done, lt, gt, eq, err, lt_cnt, gt_cnt, eq_cnt});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_word('{3'd0, 3'd0, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, 0, "basic_gt");
        run_word('{3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd2}, 0, "basic_lt");
        run_word('{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 0, "basic_lsb_lt");
    endtask

    task automatic test_gaps;
        run_word('{default: 3'd0}, 3, "gaps_eq");
    endtask

    task automatic test_err;
        run_word('{3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 0, "err_both");
        run_word('{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 0, "err_clear_lt");
        run_word('{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 0, "err_none_last");
        run_word('{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 0, "err_all");
    endtask

    task automatic test_ignore;
        word_t w = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
        model_push(w);
        @(negedge clk) begin start = 1'b1; set_bit(3'd1); end
        @(negedge clk) begin start = 1'b0; bit_valid = 1'b0; end
        for (int i = 0; i < 7; i++) begin
            if (i == 3) start = 1'b1;
            send_bit(w[i], 0);
            start = 1'b0;
        end
        n_checks++;
        if ({done, busy} !== 2'b01) $display("FAIL ignore_idle_bit: done/busy got %b want 01", {done, busy});
        else n_pass++;
        send_bit(w[7], 0);
        start = 1'b1;
        set_bit(3'd1);
        finish_word("ignore");
        start = 1'b0;
        bit_valid = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL ignore_done_start: busy/done got %b want 00", {busy, done});
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int nd;
        do_start();
        for (int i = 0; i < 3; i++) send_bit(3'd1, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, lt, gt, eq, err, lt_cnt, gt_cnt, eq_cnt, lt_cnt2, gt_cnt2, eq_cnt2} !== 36'd0)
            $display("FAIL midrun_reset: got %h want 0",
                     {busy, done, lt, gt, eq, err, lt_cnt, gt_cnt, eq_cnt, lt_cnt2, gt_cnt2, eq_cnt2});
        else n_pass++;
        m_lc = 0; m_gc = 0; m_ec = 0; m_lc2 = 0; m_gc2 = 0; m_ec2 = 0;
        nd = n_done;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(3'd1, 0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_done != nd || busy !== 1'b0) $display("FAIL midrun_no_done: done_pulses=%0d busy=%b want %0d busy=0", n_done, busy, nd);
        else n_pass++;
    endtask

    task automatic test_saturate;
        logic [1:0] want2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int n = 0; n < 5; n++) begin
            run_word('{3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 0, "sat");
            n_checks++;
            if (lt_cnt2 !== want2[n] || lt_cnt !== 8'(n + 1))
                $display("FAIL sat_seq%0d: lt_cnt2=%0d lt_cnt=%0d want %0d and %0d", n, lt_cnt2, lt_cnt, want2[n], n + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        word_t w;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 8; i++) begin
                int r = int'($urandom_range(0, 19));
                w[i] = r < 14 ? 3'd0 : r < 16 ? 3'd1 : r < 18 ? 3'd2 : r == 18 ? 3'd3 : 3'd4;
            end
            run_word(w, n % 2, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_err();
        test_ignore();
        test_reset_mid_run();
        test_saturate();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
